// File: rtl/memory_responder_pkg.sv
// Shared types and sizing helpers for the memory responder.
// Range checking is selected by MEMORY_RESPONDER_RANGE_CHECK_EN in the top module.
package memory_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } memory_responder_state_t;

    localparam int unsigned DEFAULT_DATA_WIDTH  = 32;
    localparam int unsigned DEFAULT_ADDR_WIDTH  = 32;
    localparam int unsigned DEFAULT_DEPTH_WORDS = 1024;

    // Latency counter holds LATENCY-1, LATENCY at most 255.
    localparam int unsigned CNT_W = 8;

    localparam int unsigned WORD_OFFSET_BITS = $clog2(DEFAULT_DATA_WIDTH / 8);
    localparam int unsigned INDEX_BITS       = $clog2(DEFAULT_DEPTH_WORDS);

    function automatic int unsigned word_offset_bits(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

    function automatic int unsigned index_bits(input int unsigned depth_words);
        return $clog2(depth_words);
    endfunction

endpackage

// File: rtl/memory_responder_if.sv
// Request/response bus between a memory master and the memory responder.
interface memory_interface
    import memory_responder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  write;
    logic                  valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  ready;

    modport master (
        output addr, wr_data, write, valid,
        input  rd_data, ready
    );

    modport slave (
        input  addr, wr_data, write, valid,
        output rd_data, ready
    );
endinterface

// File: rtl/memory_responder_ram.sv
// Single-port synchronous word array: write enable plus one-cycle registered read.
module memory_responder_ram
    import memory_responder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int unsigned IDX_W       = INDEX_BITS
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [IDX_W-1:0]      addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Storage carries no reset; contents are undefined until written.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/memory_responder.sv
// Fixed-latency memory responder: accepts one access in IDLE, waits LATENCY cycles, completes in DONE.
// Define MEMORY_RESPONDER_RANGE_CHECK_EN for out-of-range detection and the sticky err_o port.
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int unsigned LATENCY     = 3
) (
    input  logic            clk_i,
    input  logic            reset_i,
    memory_interface.slave  memory_bus
`ifdef MEMORY_RESPONDER_RANGE_CHECK_EN
    ,
    output logic            err_o
`endif
);
    localparam int unsigned OFF_W = word_offset_bits(DATA_WIDTH);
    localparam int unsigned IDX_W = index_bits(DEPTH_WORDS);

    memory_responder_state_t state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [IDX_W-1:0]        idx_q;
    logic [DATA_WIDTH-1:0]   wr_data_q;
    logic [DATA_WIDTH-1:0]   rd_data_q;
    logic                    write_q;
    logic                    ready_q;
    logic                    oor_q;

    logic [IDX_W-1:0]        req_idx_c;
    logic                    req_oor_c;
    logic                    last_c;
    logic                    ram_we_c;
    logic                    ram_re_c;
    logic [IDX_W-1:0]        ram_addr_c;
    logic [DATA_WIDTH-1:0]   ram_rdata;
    logic                    unused_addr_c;

    assign req_idx_c     = memory_bus.addr[OFF_W +: IDX_W];
    assign unused_addr_c = ^memory_bus.addr;

`ifdef MEMORY_RESPONDER_RANGE_CHECK_EN
    localparam int unsigned TAG_LSB = OFF_W + IDX_W;

    assign req_oor_c = (memory_bus.addr >> TAG_LSB) != '0;
`else
    assign req_oor_c = 1'b0;
`endif

    // The array is read at the accept edge and every BUSY edge, so the word is
    // already in the RAM output register when the final BUSY edge captures it.
    always_comb begin
        last_c     = 1'b0;
        ram_we_c   = 1'b0;
        ram_re_c   = 1'b0;
        ram_addr_c = idx_q;
        if (state_q == IDLE) begin
            ram_addr_c = req_idx_c;
            ram_re_c   = memory_bus.valid;
        end else if (state_q == BUSY) begin
            last_c   = (cnt_q == '0);
            ram_re_c = !write_q;
            ram_we_c = last_c && write_q && !oor_q;
        end
    end

    memory_responder_ram #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we_c),
        .re_i    (ram_re_c),
        .addr_i  (ram_addr_c),
        .wdata_i (wr_data_q),
        .rdata_o (ram_rdata)
    );

    // Access sequencer: request latch, latency countdown, completion hold.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            wr_data_q <= '0;
            rd_data_q <= '0;
            write_q   <= 1'b0;
            ready_q   <= 1'b1;
            oor_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (memory_bus.valid) begin
                        idx_q     <= req_idx_c;
                        wr_data_q <= memory_bus.wr_data;
                        write_q   <= memory_bus.write;
                        oor_q     <= req_oor_c;
                        cnt_q     <= CNT_W'(LATENCY - 1);
                        ready_q   <= 1'b0;
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        if (!write_q) begin
                            rd_data_q <= oor_q ? '1 : ram_rdata;
                        end
                        ready_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (!memory_bus.valid) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef MEMORY_RESPONDER_RANGE_CHECK_EN
    logic err_q;

    // Sticky until reset once any out-of-range access completes.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            err_q <= 1'b0;
        end else if (last_c && oor_q) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`endif

    assign memory_bus.rd_data = rd_data_q;
    assign memory_bus.ready   = ready_q;
endmodule

// File: tb/tb_memory_responder.sv
// Randomized bench for memory_responder: three instances (LATENCY 3, 1, 8) against a transaction-level model.
module tb_memory_responder;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 1024;
    localparam int          NL    = 3;

    function automatic int unsigned lat_of(input int l);
        case (l)
            0:       return 3;
            1:       return 1;
            default: return 8;
        endcase
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0] addr_a [NL];
    logic [DW-1:0] wd_a   [NL];
    logic          wr_a   [NL];
    logic          val_a  [NL];
    logic          rst_a  [NL];
    logic [DW-1:0] rd_a   [NL];
    logic          rdy_a  [NL];
`ifdef MEMORY_RESPONDER_RANGE_CHECK_EN
    logic          err_a  [NL];
`endif

    for (genvar g = 0; g < NL; g++) begin : g_lane
        memory_interface #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
        assign bus.addr    = addr_a[g];
        assign bus.wr_data = wd_a[g];
        assign bus.write   = wr_a[g];
        assign bus.valid   = val_a[g];
        assign rd_a[g]     = bus.rd_data;
        assign rdy_a[g]    = bus.ready;

        memory_responder #(
            .DATA_WIDTH  (DW),
            .ADDR_WIDTH  (AW),
            .DEPTH_WORDS (DEPTH),
            .LATENCY     (lat_of(g))
        ) u_dut (
            .clk_i      (clk),
            .reset_i    (rst_a[g]),
            .memory_bus (bus)
`ifdef MEMORY_RESPONDER_RANGE_CHECK_EN
            ,
            .err_o      (err_a[g])
`endif
        );
    end

    // Model: word array per instance plus the values each output must show.
    logic [DW-1:0] mdl_mem   [NL][DEPTH];
    logic [DW-1:0] exp_rd    [NL];
    logic          exp_ready [NL];
    logic          exp_err   [NL];
    int            low_run   [NL];
    int            last_low  [NL];
    int            n_pass = 0;
    int            n_tot  = 0;

    task automatic check(input string name, input int l, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s lane%0d: got %h, want %h at %0t", name, l, act, exp, $time);
    endtask

    // One clock: compare every instance at the falling edge, then step past the rising edge.
    task automatic tick();
        @(negedge clk);
        for (int l = 0; l < NL; l++) begin
            if (!rst_a[l]) begin
                check("ready", l, DW'(rdy_a[l]), DW'(exp_ready[l]));
                check("rd_data", l, rd_a[l], exp_rd[l]);
`ifdef MEMORY_RESPONDER_RANGE_CHECK_EN
                check("err_o", l, DW'(err_a[l]), DW'(exp_err[l]));
`endif
            end
            if (!rdy_a[l]) low_run[l]++;
            else if (low_run[l] != 0) begin
                last_low[l] = low_run[l];
                low_run[l]  = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Full access: accept, LATENCY busy cycles with scrambled inputs, then hold valid for `hold` cycles in DONE.
    task automatic access(input int l, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input int hold);
        int unsigned lat;
        int unsigned idx;
        bit          oor;
        lat = lat_of(l);
        idx = 32'((a >> 2) % DEPTH);
        oor = ((a >> 2) >= DEPTH);
        addr_a[l] = a;
        wd_a[l]   = d;
        wr_a[l]   = wr;
        val_a[l]  = 1'b1;
        tick();
        exp_ready[l] = 1'b0;
        for (int i = 0; i < int'(lat); i++) begin
            addr_a[l] = $urandom;
            wd_a[l]   = $urandom;
            wr_a[l]   = 1'($urandom_range(0, 1));
            val_a[l]  = 1'($urandom_range(0, 1));
            tick();
        end
`ifdef MEMORY_RESPONDER_RANGE_CHECK_EN
        if (oor) exp_err[l] = 1'b1;
        if (wr) begin
            if (!oor) mdl_mem[l][idx] = d;
        end else begin
            exp_rd[l] = oor ? '1 : mdl_mem[l][idx];
        end
`else
        if (wr) mdl_mem[l][idx] = d;
        else    exp_rd[l] = mdl_mem[l][idx];
`endif
        exp_ready[l] = 1'b1;
        for (int i = 0; i < hold; i++) begin
            val_a[l]  = 1'b1;
            addr_a[l] = $urandom;
            wr_a[l]   = 1'($urandom_range(0, 1));
            tick();
        end
        val_a[l] = 1'b0;
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", n_pass, n_tot);
        $fatal(1, "watchdog");
    end

    initial begin
        int            ln;
        logic [AW-1:0] a;
        logic [DW-1:0] d;

        for (int l = 0; l < NL; l++) begin
            rst_a[l]     = 1'b1;
            val_a[l]     = 1'b0;
            addr_a[l]    = '0;
            wd_a[l]      = '0;
            wr_a[l]      = 1'b0;
            exp_ready[l] = 1'b1;
            exp_rd[l]    = '0;
            exp_err[l]   = 1'b0;
            low_run[l]   = 0;
            last_low[l]  = 0;
        end
        #12;
        for (int l = 0; l < NL; l++) begin
            check("reset_ready", l, DW'(rdy_a[l]), 32'd1);
            check("reset_rd_data", l, rd_a[l], 32'd0);
        end
        @(posedge clk);
        #1;
        for (int l = 0; l < NL; l++) rst_a[l] = 1'b0;

        // Give every word the random traffic can reach a defined value.
        for (int l = 0; l < NL; l++) begin
            for (int i = 0; i < 16; i++) begin
                d = $urandom;
                if (l == 0 && i == 0) d = 32'h0BAD_0000;
                if (l == 0 && i == 8) d = 32'hA5A5_0020;
                access(l, 1'b1, AW'(i * 4), d, 0);
            end
        end

        access(0, 1'b1, 32'h10, 32'hCAFE_BABE, 0);
        check("write_latency", 0, DW'(last_low[0]), 32'd3);
        access(0, 1'b0, 32'h10, $urandom, 0);
        check("read_value", 0, rd_a[0], 32'hCAFE_BABE);
        check("read_latency", 0, DW'(last_low[0]), 32'd3);

        access(1, 1'b0, 32'h0, $urandom, 0);
        check("latency1", 1, DW'(last_low[1]), 32'd1);
        access(2, 1'b0, 32'h0, $urandom, 0);
        check("latency8", 2, DW'(last_low[2]), 32'd8);

        access(0, 1'b0, 32'h10, $urandom, 5);
        check("done_hold_rd", 0, rd_a[0], 32'hCAFE_BABE);

        // Reset in the second busy cycle of a write must abandon it.
        addr_a[0] = 32'h20;
        wd_a[0]   = 32'h1234_5678;
        wr_a[0]   = 1'b1;
        val_a[0]  = 1'b1;
        tick();
        exp_ready[0] = 1'b0;
        addr_a[0] = $urandom;
        wd_a[0]   = $urandom;
        tick();
        #2 rst_a[0] = 1'b1;
        #1;
        check("async_rst_ready", 0, DW'(rdy_a[0]), 32'd1);
        check("async_rst_rd_data", 0, rd_a[0], 32'd0);
        exp_ready[0] = 1'b1;
        exp_rd[0]    = '0;
        exp_err[0]   = 1'b0;
        val_a[0]     = 1'b0;
        tick();
        rst_a[0] = 1'b0;
        tick();
        tick();
        access(0, 1'b0, 32'h20, $urandom, 0);
        check("rst_no_write", 0, rd_a[0], 32'hA5A5_0020);

        access(0, 1'b1, 32'h1000, 32'h55AA_55AA, 0);
`ifdef MEMORY_RESPONDER_RANGE_CHECK_EN
        check("oor_err", 0, DW'(err_a[0]), 32'd1);
        access(0, 1'b0, 32'h0, $urandom, 0);
        check("oor_write_dropped", 0, rd_a[0], 32'h0BAD_0000);
        access(0, 1'b0, 32'h1000, $urandom, 0);
        check("oor_read_ones", 0, rd_a[0], 32'hFFFF_FFFF);
`else
        access(0, 1'b0, 32'h1000, $urandom, 0);
        check("alias_read", 0, rd_a[0], 32'h55AA_55AA);
        access(0, 1'b0, 32'h0, $urandom, 0);
        check("alias_word0", 0, rd_a[0], 32'h55AA_55AA);
`endif

        for (int k = 0; k < 200; k++) begin
            ln = $urandom_range(0, NL - 1);
            a  = AW'($urandom_range(0, 15)) * 4 + AW'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a | (AW'($urandom_range(1, 15)) << 12);
            access(ln, 1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
